// File: rtl/mac_pkg.sv
// Shared definitions for the GMII receive MAC.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP,
    ST_DONE
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned LEN_W = 11;

  // Bit positions inside o_err = {overflow, len, crc, rxer}
  localparam int unsigned ERR_RXER = 0;
  localparam int unsigned ERR_CRC  = 1;
  localparam int unsigned ERR_LEN  = 2;
  localparam int unsigned ERR_OVF  = 3;

endpackage

// File: rtl/mac_rx_crc32_d8.sv
// Byte-wide Ethernet CRC-32 register. Register is kept in MSB-first form
// with data bits fed LSB first, so a clean frame+FCS leaves CRC_RESIDUE.
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] work;

  // Next-state: clear has priority, otherwise fold in one byte when enabled
  always_comb begin
    crc_d = crc_q;
    work  = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (work[31] ^ data_i[i]) begin
          work = {work[30:0], 1'b0} ^ CRC_POLY;
        end else begin
          work = {work[30:0], 1'b0};
        end
      end
      crc_d = work;
    end
  end

  // CRC state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mac_rx.sv
// GMII receive MAC: strips preamble/SFD, writes frame bytes into a circular
// buffer, checks CRC-32, commits good frames and rolls back bad ones.
// Optional destination-address filter: define MAC_RX_ADDR_FILTER_EN.
module mac_rx
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MIN_FRAME  = 64,
  parameter int unsigned MAX_FRAME  = 1518
) (
  input  logic                  i_gclk,
  input  logic                  i_rst,
`ifdef MAC_RX_ADDR_FILTER_EN
  input  logic [47:0]           i_mac_addr,
`endif
  input  logic                  i_eth_rxdv,
  input  logic                  i_eth_rxer,
  input  logic [7:0]            i_eth_rxd,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_frame_valid,
  output logic                  o_frame_good,
  output logic [ADDR_WIDTH-1:0] o_frame_st,
  output logic [ADDR_WIDTH-1:0] o_frame_ed,
  output logic [LEN_W-1:0]      o_frame_len,
  output logic [3:0]            o_err
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] commit_q;
  logic [ADDR_WIDTH-1:0] st_q;
  logic [LEN_W-1:0]      count_q;
  logic [3:0]            flags_q;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  frame_valid_q;
  logic                  frame_good_q;
  logic [ADDR_WIDTH-1:0] frame_st_q;
  logic [ADDR_WIDTH-1:0] frame_ed_q;
  logic [LEN_W-1:0]      frame_len_q;
  logic [3:0]            err_q;

  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [ADDR_WIDTH-1:0] good_end;
  logic [ADDR_WIDTH-1:0] frame_ed_d;
  logic                  pre_sfd;
  logic                  byte_ok;
  logic [3:0]            done_flags;
  logic                  addr_reject;
  logic [31:0]           crc_val;

`ifdef MAC_RX_ADDR_FILTER_EN
  logic                  ucast_q;
  logic                  bcast_q;
  logic [7:0]            mac_byte;

  // Destination byte expected at the current DATA index, first byte = [47:40]
  always_comb begin
    mac_byte = '0;
    case (count_q[2:0])
      3'd0:    mac_byte = i_mac_addr[47:40];
      3'd1:    mac_byte = i_mac_addr[39:32];
      3'd2:    mac_byte = i_mac_addr[31:24];
      3'd3:    mac_byte = i_mac_addr[23:16];
      3'd4:    mac_byte = i_mac_addr[15:8];
      3'd5:    mac_byte = i_mac_addr[7:0];
      default: mac_byte = '0;
    endcase
  end
`endif

  // Datapath decode for the current cycle
  always_comb begin
    ptr_nxt    = wr_ptr_q + 1'b1;
    good_end   = st_q + ADDR_WIDTH'(count_q) - ADDR_WIDTH'(4);
    frame_ed_d = st_q + ADDR_WIDTH'(count_q) - ADDR_WIDTH'(5);
    pre_sfd    = (state_q == ST_PRE) && i_eth_rxdv && !i_eth_rxer &&
                 (i_eth_rxd == SFD_BYTE);
    byte_ok    = (state_q == ST_DATA) && i_eth_rxdv && !i_eth_rxer &&
                 (count_q != LEN_W'(MAX_FRAME)) && (ptr_nxt != i_rd_addr);
  end

  // End-of-frame verdict; an abort reason from DATA is reported on its own,
  // CRC and runt checks only apply to frames that ended normally
  always_comb begin
    done_flags = flags_q;
    if (flags_q == '0) begin
      done_flags[ERR_CRC] = (crc_val != CRC_RESIDUE);
      done_flags[ERR_LEN] = (count_q < LEN_W'(MIN_FRAME));
    end
  end

  // Address filter verdict
  always_comb begin
    addr_reject = 1'b0;
`ifdef MAC_RX_ADDR_FILTER_EN
    addr_reject = !(ucast_q || bcast_q);
`endif
  end

  crc32_d8 u_crc (
    .clk_i  (i_gclk),
    .rst_i  (i_rst),
    .clr_i  (pre_sfd),
    .en_i   (byte_ok),
    .data_i (i_eth_rxd),
    .crc_o  (crc_val)
  );

  // Receive FSM with registered buffer-write and frame-report outputs
  always_ff @(posedge i_gclk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      commit_q      <= '0;
      st_q          <= '0;
      count_q       <= '0;
      flags_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_good_q  <= 1'b0;
      frame_st_q    <= '0;
      frame_ed_q    <= '0;
      frame_len_q   <= '0;
      err_q         <= '0;
`ifdef MAC_RX_ADDR_FILTER_EN
      ucast_q       <= 1'b0;
      bcast_q       <= 1'b0;
`endif
    end else begin
      wr_en_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_eth_rxdv && (i_eth_rxd == PREAMBLE_BYTE)) begin
            state_q <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (pre_sfd) begin
            state_q  <= ST_DATA;
            st_q     <= commit_q;
            wr_ptr_q <= commit_q;
            count_q  <= '0;
            flags_q  <= '0;
`ifdef MAC_RX_ADDR_FILTER_EN
            ucast_q  <= 1'b1;
            bcast_q  <= 1'b1;
`endif
          end else if (!(i_eth_rxdv && !i_eth_rxer &&
                         (i_eth_rxd == PREAMBLE_BYTE))) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!i_eth_rxdv) begin
            state_q <= ST_DONE;
          end else if (i_eth_rxer) begin
            flags_q[ERR_RXER] <= 1'b1;
            state_q           <= ST_DROP;
          end else if (count_q == LEN_W'(MAX_FRAME)) begin
            flags_q[ERR_LEN] <= 1'b1;
            state_q          <= ST_DROP;
          end else if (ptr_nxt == i_rd_addr) begin
            flags_q[ERR_OVF] <= 1'b1;
            state_q          <= ST_DROP;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_ptr_q;
            wr_data_q <= i_eth_rxd;
            wr_ptr_q  <= ptr_nxt;
            count_q   <= count_q + 1'b1;
`ifdef MAC_RX_ADDR_FILTER_EN
            if (count_q < LEN_W'(6)) begin
              ucast_q <= ucast_q && (i_eth_rxd == mac_byte);
              bcast_q <= bcast_q && (i_eth_rxd == BCAST_MAC[7:0]);
            end
`endif
          end
        end
        ST_DROP: begin
          if (!i_eth_rxdv) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (addr_reject) begin
            wr_ptr_q <= commit_q;
          end else begin
            frame_valid_q <= 1'b1;
            frame_good_q  <= (done_flags == '0);
            err_q         <= done_flags;
            frame_st_q    <= st_q;
            frame_ed_q    <= frame_ed_d;
            frame_len_q   <= count_q - LEN_W'(4);
            if (done_flags == '0) begin
              commit_q <= good_end;
              wr_ptr_q <= good_end;
            end else begin
              wr_ptr_q <= commit_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_good  = frame_good_q;
  assign o_frame_st    = frame_st_q;
  assign o_frame_ed    = frame_ed_q;
  assign o_frame_len   = frame_len_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_mac_rx.sv
// Directed self-checking bench for mac_rx.
module tb_mac_rx;

  localparam int unsigned AW = 11;
  localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxdv = 1'b0;
  logic          rxer = 1'b0;
  logic [7:0]    rxd = '0;
  logic [AW-1:0] rd_addr = 11'd2000;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          fvalid;
  logic          fgood;
  logic [AW-1:0] fst;
  logic [AW-1:0] fed;
  logic [10:0]   flen;
  logic [3:0]    ferr;
`ifdef MAC_RX_ADDR_FILTER_EN
  logic [47:0]   mac_addr = MY_MAC;
`endif

  mac_rx #(.ADDR_WIDTH(AW), .MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .i_gclk        (clk),
    .i_rst         (rst),
`ifdef MAC_RX_ADDR_FILTER_EN
    .i_mac_addr    (mac_addr),
`endif
    .i_eth_rxdv    (rxdv),
    .i_eth_rxer    (rxer),
    .i_eth_rxd     (rxd),
    .i_rd_addr     (rd_addr),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_frame_valid (fvalid),
    .o_frame_good  (fgood),
    .o_frame_st    (fst),
    .o_frame_ed    (fed),
    .o_frame_len   (flen),
    .o_err         (ferr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_b [0:1599];
  logic [7:0] mem [0:2047];
  int         wr_cnt = 0;
  int         wr_first = 0;
  int         wr_last = 0;
  int         vcnt = 0;
  int         vbase = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the buffer write port and frame reports between clock edges
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      if (wr_cnt == 0) wr_first = int'(wr_addr);
      wr_last = int'(wr_addr);
      wr_cnt++;
    end
    if (fvalid) vcnt++;
  end

  // Reflected software CRC-32 over the first n bytes, final value inverted
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_b[i]};
      for (int b = 0; b < 8; b++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic build(input int n, input logic [47:0] dest);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) frame_b[i] = 8'((i * 7 + 3) & 255);
    for (int i = 0; i < 6; i++) frame_b[i] = dest[47 - 8*i -: 8];
    f = fcs_of(n - 4);
    frame_b[n-4] = f[7:0];
    frame_b[n-3] = f[15:8];
    frame_b[n-2] = f[23:16];
    frame_b[n-1] = f[31:24];
  endtask

  task automatic send(input int n, input int rxer_at);
    wr_cnt = 0;
    vbase  = vcnt;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      rxdv = 1'b1; rxd = 8'h55;
      @(posedge clk); #1;
    end
    rxd = 8'hD5;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      rxd  = frame_b[i];
      rxer = (i == rxer_at);
      @(posedge clk); #1;
    end
    rxdv = 1'b0; rxer = 1'b0; rxd = '0;
  endtask

  task automatic wait_report(input string tag, input int exp_pulses);
    int n;
    n = 0;
    while (vcnt == vbase && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_pulses"}, vcnt - vbase, exp_pulses);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic report(input string tag, input logic good, input logic [3:0] err,
                        input int st, input int ed, input int len);
    check({tag, "_good"}, fgood, good);
    check({tag, "_err"},  ferr, err);
    check({tag, "_st"},   fst, st);
    check({tag, "_ed"},   fed, ed);
    check({tag, "_len"},  flen, len);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_valid", fvalid, 0);
    check("rst_len", flen, 0);
    check("rst_err", ferr, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good 64-byte frame at 0
    build(64, MY_MAC);
    send(64, -1);
    wait_report("a", 1);
    report("a", 1'b1, 4'b0000, 0, 59, 60);
    check("a_wrcnt", wr_cnt, 64);
    check("a_first", wr_first, 0);
    check("a_last", wr_last, 63);
    check("a_mem20", mem[20], frame_b[20]);

    // Next good frame starts where the previous one's FCS was
    send(64, -1);
    wait_report("b", 1);
    report("b", 1'b1, 4'b0000, 60, 119, 60);
    check("b_first", wr_first, 60);

    // Reset mid-frame: no report, outputs cleared
    vbase = vcnt;
    rxdv = 1'b1; rxd = 8'h55;
    repeat (7) @(posedge clk);
    #1;
    rxd = 8'hD5;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rxd = frame_b[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    rxdv = 1'b0;
    @(posedge clk); #1;
    check("mrst_len", flen, 0);
    check("mrst_st", fst, 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mrst_pulses", vcnt - vbase, 0);

    // Corrupted payload byte 20
    build(64, MY_MAC);
    frame_b[20] = frame_b[20] ^ 8'h01;
    send(64, -1);
    wait_report("c", 1);
    report("c", 1'b0, 4'b0010, 0, 59, 60);

    // rxer at byte 30
    build(64, MY_MAC);
    send(64, 30);
    wait_report("d", 1);
    check("d_good", fgood, 0);
    check("d_err", ferr, 4'b0001);
    check("d_wrcnt", wr_cnt, 30);
    check("d_first", wr_first, 0);

    // Rollback: next good frame starts at 0
    send(64, -1);
    wait_report("e", 1);
    report("e", 1'b1, 4'b0000, 0, 59, 60);

    // Runt frame with valid CRC
    build(40, MY_MAC);
    send(40, -1);
    wait_report("f", 1);
    report("f", 1'b0, 4'b0100, 60, 95, 36);

    // Oversize frame: writes stop at MAX_FRAME
    build(1600, MY_MAC);
    send(1600, -1);
    wait_report("g", 1);
    check("g_good", fgood, 0);
    check("g_err", ferr, 4'b0100);
    check("g_wrcnt", wr_cnt, 1518);

    // Move commit pointer to 1574, then to 40 with a wrapping frame
    build(1518, MY_MAC);
    send(1518, -1);
    wait_report("i1", 1);
    report("i1", 1'b1, 4'b0000, 60, 1573, 1514);
    rd_addr = 11'd1000;
    build(518, MY_MAC);
    send(518, -1);
    wait_report("i2", 1);
    report("i2", 1'b1, 4'b0000, 1574, 39, 514);

    // Overflow against the consumer pointer
    rd_addr = 11'd100;
    build(100, MY_MAC);
    send(100, -1);
    wait_report("h", 1);
    check("h_good", fgood, 0);
    check("h_err", ferr, 4'b1000);
    check("h_st", fst, 40);
    check("h_wrcnt", wr_cnt, 59);
    check("h_last", wr_last, 98);

    // Pointer back at 40; walk commit to 2020
    rd_addr = 11'd2000;
    build(1518, MY_MAC);
    send(1518, -1);
    wait_report("j1", 1);
    report("j1", 1'b1, 4'b0000, 40, 1553, 1514);
    rd_addr = 11'd1000;
    build(470, MY_MAC);
    send(470, -1);
    wait_report("j2", 1);
    check("j2_st", fst, 1554);
    check("j2_good", fgood, 1);

    // Frame straddling address 0
    build(64, MY_MAC);
    send(64, -1);
    wait_report("k", 1);
    report("k", 1'b1, 4'b0000, 2020, 31, 60);
    check("k_first", wr_first, 2020);
    check("k_last", wr_last, 35);
    check("k_mem0", mem[0], frame_b[28]);

`ifdef MAC_RX_ADDR_FILTER_EN
    // Foreign unicast is dropped silently; broadcast is accepted
    build(64, 48'h02_99_88_77_66_55);
    send(64, -1);
    wait_report("x", 0);
    build(64, 48'hFFFF_FFFF_FFFF);
    send(64, -1);
    wait_report("y", 1);
    report("y", 1'b1, 4'b0000, 32, 91, 60);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
